// File: rtl/vsmac_pipe.sv
// vsmac_pipe: pipelined vector-scalar multiply-accumulate engine.
//
// Each accepted beat multiplies SIZE signed lanes of `a` by the signed scalar
// `b`. The products are accumulated at full precision (ACC_W, wrapping) over a
// group of beats framed by in_first / in_last. The group result is
// requantised (arithmetic shift right by SHIFT, then clamp or wrap to OUT_W)
// into a single output register.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   reset        - asynchronous, active-low; clears all state
//   in_valid     - input beat valid
//   in_ready     - input beat accepted when in_valid & in_ready at an edge
//   in_first     - beat starts a group (accumulator replaced, not added)
//   in_last      - beat ends a group (result produced)
//   a            - SIZE x DATA_W signed vector, lane 0 in the MSBs
//   b            - DATA_W signed scalar
//   out_valid    - output register holds a result
//   out_ready    - result consumed when out_valid & out_ready at an edge
//   out          - SIZE x OUT_W requantised result, lane 0 in the MSBs
//   out_overflow - some lane clamped / lost significant bits; qualified by out_valid
module vsmac_pipe #(
  parameter int unsigned SIZE     = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SHIFT    = 0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [SIZE*DATA_W-1:0] a,
  input  logic [DATA_W-1:0]      b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE*OUT_W-1:0]  out,
  output logic                   out_overflow
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  // Bits of the shifted value that must all agree for it to fit in OUT_W signed.
  localparam int unsigned HI_W   = ACC_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Full-precision signed lane product.
  function automatic logic [PROD_W-1:0] mul_lane(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ys;
    xs = $signed({{DATA_W{x[DATA_W-1]}}, x});
    ys = $signed({{DATA_W{y[DATA_W-1]}}, y});
    return PROD_W'(xs * ys);
  endfunction

  // Pipeline state
  logic                        s1_valid;
  logic                        s1_first;
  logic                        s1_last;
  logic [SIZE-1:0][PROD_W-1:0] prod;
  logic [SIZE-1:0][ACC_W-1:0]  acc;

  // Combinational datapath
  logic                        advance;
  logic                        load;
  logic [SIZE-1:0][PROD_W-1:0] prod_c;
  logic [SIZE-1:0][ACC_W-1:0]  acc_nxt_c;
  logic [SIZE-1:0][ACC_W-1:0]  q_c;
  logic [SIZE-1:0][HI_W-1:0]   hi_c;
  logic [SIZE-1:0][OUT_W-1:0]  lane_c;
  logic [SIZE-1:0]             ovf_c;
  logic [SIZE*OUT_W-1:0]       out_nxt_c;

  // The whole pipe moves only when the output register can take a result.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign load     = advance & s1_valid & s1_last;

  // Stage-1 products, lane 0 taken from the MSBs of `a`.
  always_comb begin
    prod_c = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      prod_c[i] = mul_lane(a[(SIZE-1-i)*DATA_W +: DATA_W], b);
    end
  end

  // Accumulate and requantise from the value the accumulator is about to take.
  always_comb begin
    acc_nxt_c = '0;
    q_c       = '0;
    hi_c      = '0;
    lane_c    = '0;
    ovf_c     = '0;
    out_nxt_c = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      acc_nxt_c[i] = (s1_first ? '0 : acc[i]) + ACC_W'($signed(prod[i]));
      q_c[i]       = ACC_W'($signed(acc_nxt_c[i]) >>> SHIFT);
      hi_c[i]      = q_c[i][ACC_W-1:OUT_W-1];
      ovf_c[i]     = ~((&hi_c[i]) | ~(|hi_c[i]));
      if (SATURATE && ovf_c[i]) begin
        lane_c[i] = q_c[i][ACC_W-1] ? OUT_MIN : OUT_MAX;
      end else begin
        lane_c[i] = q_c[i][OUT_W-1:0];
      end
      out_nxt_c[(SIZE-1-i)*OUT_W +: OUT_W] = lane_c[i];
    end
  end

  // Stage 1: product register; a cycle with no beat leaves a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      prod     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        prod     <= prod_c;
      end
    end
  end

  // Stage 2: per-lane accumulator, wraps modulo 2^ACC_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (advance && s1_valid) begin
      acc <= acc_nxt_c;
    end
  end

  // Output register; a new result may replace one being consumed on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out          <= '0;
      out_valid    <= 1'b0;
      out_overflow <= 1'b0;
    end else if (load) begin
      out          <= out_nxt_c;
      out_valid    <= 1'b1;
      out_overflow <= |ovf_c;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vsmac_pipe.sv
// tb_vsmac_pipe: self-checking bench for vsmac_pipe.
// Three instances share one stimulus stream: saturating (defaults), wrapping
// (SATURATE=0) and shifted (SHIFT=8). Every result leaving the pipe is compared
// with an integer model of the group arithmetic; directed scenarios add fixed
// expected values, latency, back-pressure and reset checks.
module tb_vsmac_pipe;

  localparam int unsigned SIZE   = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned AW     = SIZE * DATA_W;
  localparam int unsigned OW     = SIZE * OUT_W;
  localparam int unsigned NDUT   = 3;

  typedef logic [NDUT-1:0][OW:0] res_t;  // per instance {overflow, out}

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_first;
  logic              in_last;
  logic              out_ready;
  logic [AW-1:0]     a;
  logic [DATA_W-1:0] b;
  logic [NDUT-1:0]   rdy;
  logic [NDUT-1:0]   ov;
  logic [NDUT-1:0]   of;
  logic [OW-1:0]     o [NDUT];

  int unsigned shift_of [NDUT] = '{0, 0, 8};
  bit          sat_of   [NDUT] = '{1'b1, 1'b0, 1'b1};

  int     n_checks   = 0;
  int     n_fail     = 0;
  int     n_results  = 0;
  int     n_expected = 0;
  longint macc [SIZE];
  res_t   expq [$];
  bit     rand_ordy  = 1'b0;
  bit     ordy_g     = 1'b1;

  logic [AW-1:0]     s1_a [3] = '{24'h010407, 24'h020508, 24'h030609};
  logic [DATA_W-1:0] s1_b [3] = '{8'h01, 8'h02, 8'h03};
  logic [AW-1:0]     s2_a [3] = '{24'h010203, 24'h010203, 24'h03FA09};
  logic [DATA_W-1:0] s2_b [3] = '{8'hFC, 8'h04, 8'hFD};

  always #5 clk = ~clk;

  vsmac_pipe u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .out(o[0]), .out_overflow(of[0])
  );

  vsmac_pipe #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .out(o[1]), .out_overflow(of[1])
  );

  vsmac_pipe #(.SHIFT(8)) u_shift (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .out(o[2]), .out_overflow(of[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reduce to a signed ACC_W-bit value (two's-complement wrap).
  function automatic longint wrap_acc(input longint v);
    longint m;
    longint r;
    m = longint'(1) << ACC_W;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  function automatic logic [OW:0] requant(input int unsigned sh, input bit sat);
    logic [OW:0] r;
    longint lo;
    longint hi;
    longint q;
    longint v;
    r  = '0;
    lo = -(longint'(1) << (OUT_W - 1));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    for (int i = 0; i < SIZE; i++) begin
      q = macc[i] >>> sh;
      v = q;
      if (q < lo || q > hi) begin
        r[OW] = 1'b1;
        if (sat) v = (q < lo) ? lo : hi;
      end
      r[OW-1-i*OUT_W -: OUT_W] = OUT_W'(v);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) macc[i] = 0;
    expq.delete();
  endtask

  task automatic model_beat(input logic [AW-1:0] va, input logic [DATA_W-1:0] vb,
                            input bit f, input bit l);
    longint bv;
    longint av;
    res_t   r;
    bv = longint'($signed(vb));
    for (int i = 0; i < SIZE; i++) begin
      av = longint'($signed(va[AW-1-i*DATA_W -: DATA_W]));
      if (f) macc[i] = 0;
      macc[i] = wrap_acc(macc[i] + av * bv);
    end
    if (l) begin
      for (int k = 0; k < NDUT; k++) r[k] = requant(shift_of[k], sat_of[k]);
      expq.push_back(r);
      n_expected++;
    end
  endtask

  // A result is leaving the output register on the coming edge.
  task automatic consume();
    res_t e;
    if (expq.size() == 0) begin
      chk("spurious_out", 64'(ov), 64'h0);
    end else begin
      e = expq.pop_front();
      for (int k = 0; k < NDUT; k++)
        chk($sformatf("result_dut%0d", k), 64'({of[k], o[k]}), 64'(e[k]));
      n_results++;
    end
  endtask

  function automatic bit next_ordy();
    return rand_ordy ? bit'($urandom_range(0, 1)) : ordy_g;
  endfunction

  // One clock: drive at the falling edge, observe handshakes, advance to next falling edge.
  task automatic step(input bit v, input logic [AW-1:0] va, input logic [DATA_W-1:0] vb,
                      input bit f, input bit l, input bit r, output bit took);
    in_valid  = v;
    a         = va;
    b         = vb;
    in_first  = f;
    in_last   = l;
    out_ready = r;
    #1;
    took = v && rdy[0];
    if (ov[0] && r) consume();
    if (took) model_beat(va, vb, f, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, next_ordy(), t);
  endtask

  task automatic send(input logic [AW-1:0] va, input logic [DATA_W-1:0] vb,
                      input bit f, input bit l);
    bit took;
    took = 1'b0;
    for (int n = 0; n < 64 && !took; n++) step(1'b1, va, vb, f, l, next_ordy(), took);
    if (!took) chk("accept_timeout", 64'(took), 64'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit took;
    int len;
    bit drop_first;
    bit drop_last;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(ov), 64'h0);
    chk("rst_out", 64'(o[0]), 64'h0);
    chk("rst_overflow", 64'(of), 64'h0);
    chk("rst_in_ready", 64'(rdy), 64'h7);
    @(negedge clk);
    reset = 1'b1;

    // Scenario 1: basic group of three, latency and single-cycle valid.
    send(s1_a[0], s1_b[0], 1'b1, 1'b0);
    send(s1_a[1], s1_b[1], 1'b0, 1'b0);
    send(s1_a[2], s1_b[2], 1'b0, 1'b1);
    chk("s1_not_yet_valid", 64'(ov[0]), 64'h0);
    idle(1);
    chk("s1_valid", 64'(ov[0]), 64'h1);
    chk("s1_out", 64'(o[0]), 64'h0E2032);
    chk("s1_overflow", 64'(of[0]), 64'h0);
    idle(1);
    chk("s1_valid_one_cycle", 64'(ov[0]), 64'h0);

    // Scenario 2: negative operands.
    for (int i = 0; i < 3; i++) send(s2_a[i], s2_b[i], i == 0, i == 2);
    idle(1);
    chk("s2_out", 64'(o[0]), 64'hF712E5);
    idle(1);

    // Scenario 3: saturate / wrap / shifted requantisation.
    send(24'h7F7F80, 8'h7F, 1'b1, 1'b0);
    send(24'h7F7F80, 8'h7F, 1'b0, 1'b1);
    idle(1);
    chk("sat_out", 64'(o[0]), 64'h7F7F80);
    chk("sat_overflow", 64'(of[0]), 64'h1);
    chk("wrap_out", 64'(o[1]), 64'h020200);
    chk("wrap_overflow", 64'(of[1]), 64'h1);
    chk("shift_out", 64'(o[2]), 64'h7E7E81);
    chk("shift_overflow", 64'(of[2]), 64'h0);
    idle(1);

    // Scenario 4: back-pressure while the next group is offered.
    ordy_g = 1'b0;
    for (int i = 0; i < 3; i++) send(s1_a[i], s1_b[i], i == 0, i == 2);
    idle(1);
    chk("bp_valid", 64'(ov[0]), 64'h1);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, s2_a[0], s2_b[0], 1'b1, 1'b0, 1'b0, took);
      chk("bp_no_accept", 64'(took), 64'h0);
      chk("bp_in_ready", 64'(rdy[0]), 64'h0);
      chk("bp_out_stable", 64'(o[0]), 64'h0E2032);
      chk("bp_valid_held", 64'(ov[0]), 64'h1);
    end
    step(1'b1, s2_a[0], s2_b[0], 1'b1, 1'b0, 1'b1, took);
    chk("bp_release_accept", 64'(took), 64'h1);
    ordy_g = 1'b1;
    send(s2_a[1], s2_b[1], 1'b0, 1'b0);
    send(s2_a[2], s2_b[2], 1'b0, 1'b1);
    idle(1);
    chk("bp_second_out", 64'(o[0]), 64'hF712E5);
    idle(1);

    // Scenario 5: bubbles between beats, then a group of one.
    for (int i = 0; i < 3; i++) begin
      send(s1_a[i], s1_b[i], i == 0, i == 2);
      if (i < 2) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    chk("bubble_out", 64'(o[0]), 64'h0E2032);
    send(24'h7F0180, 8'h02, 1'b1, 1'b1);
    idle(1);
    chk("one_beat_out", 64'(o[0]), 64'h7F0280);
    chk("one_beat_overflow", 64'(of[0]), 64'h1);
    idle(1);

    // Scenario 6: asynchronous reset in the middle of a group.
    send(s1_a[0], s1_b[0], 1'b1, 1'b0);
    send(s1_a[1], s1_b[1], 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov), 64'h0);
    chk("midrst_out", 64'(o[0]), 64'h0);
    chk("midrst_overflow", 64'(of), 64'h0);
    chk("midrst_in_ready", 64'(rdy), 64'h7);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("postrst_in_ready", 64'(rdy), 64'h7);
    // A beat without first must land on a cleared accumulator.
    send(24'h010203, 8'h01, 1'b0, 1'b1);
    idle(1);
    chk("postrst_acc_clear", 64'(o[0]), 64'h010203);
    for (int i = 0; i < 3; i++) send(s1_a[i], s1_b[i], i == 0, i == 2);
    idle(1);
    chk("postrst_s1_out", 64'(o[0]), 64'h0E2032);
    idle(1);

    // Random groups with random bubbles, abandoned groups and back-pressure.
    rand_ordy = 1'b1;
    for (int g = 0; g < 150; g++) begin
      len        = int'($urandom_range(1, 5));
      drop_first = ($urandom_range(0, 9) == 0);
      drop_last  = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < len; j++) begin
        send(AW'($urandom()), DATA_W'($urandom()),
             (j == 0) && !drop_first, (j == len - 1) && !drop_last);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    rand_ordy = 1'b0;
    ordy_g    = 1'b1;
    for (int n = 0; n < 20 && (expq.size() > 0 || ov[0]); n++) idle(1);
    chk("drain_queue_empty", 64'(expq.size()), 64'h0);
    chk("results_delivered", 64'(n_results), 64'(n_expected));
    chk("drain_out_valid", 64'(ov), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
